// File: rtl/nway_prefetch_cache_ctrl.sv
// rtl/nway_prefetch_cache_ctrl.sv - N-way cache control FSM with sequential next-N-line prefetch
// Optional statistics counters enabled by defining PF_STATS_EN.
module nway_prefetch_cache_ctrl #(
  parameter int WAYS     = 4,
  parameter int WAY_W    = $clog2(WAYS),
  parameter int PF_DEPTH = 2,
  parameter int CNT_W    = (PF_DEPTH < 1) ? 1 : $clog2(PF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             pmem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             hit,
  input  logic [WAY_W-1:0] hit_way,
  input  logic [WAY_W-1:0] victim_way,
  input  logic             victim_dirty,
  input  logic             pf_cross_page,
  output logic [1:0]       pmem_addr_sel,
  output logic             lookup_sel,
  output logic             data_in_sel,
  output logic [WAYS-1:0]  data_we,
  output logic [WAYS-1:0]  ld_tag,
  output logic [WAYS-1:0]  ld_valid,
  output logic [WAYS-1:0]  ld_dirty,
  output logic             valid_in,
  output logic             dirty_in,
  output logic             ld_lru,
`ifdef PF_STATS_EN
  output logic [15:0]      pf_issued_cnt,
  output logic [15:0]      pf_dropped_cnt,
`endif
  output logic [CNT_W-1:0] pf_offset
);

  typedef enum logic [2:0] {
    CHECK    = 3'd0,
    WB       = 3'd1,
    FILL     = 3'd2,
    PF_PROBE = 3'd3,
    PF_FILL  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pf_remaining_q, pf_remaining_d;
  logic [CNT_W-1:0] pf_offset_q, pf_offset_d;

  logic [WAYS-1:0]  hit_oh, victim_oh;
  logic [CNT_W-1:0] rem_dec;
  logic             demand;

  assign hit_oh    = {{(WAYS-1){1'b0}}, 1'b1} << hit_way;
  assign victim_oh = {{(WAYS-1){1'b0}}, 1'b1} << victim_way;
  assign rem_dec   = (pf_remaining_q == '0) ? '0 : pf_remaining_q - CNT_W'(1);
  assign demand    = mem_read | mem_write;
  assign pf_offset = pf_offset_q;

  // Next-state and datapath controls; everything is forced to 0 while reset is held
  always_comb begin
    state_d        = state_q;
    pf_remaining_d = pf_remaining_q;
    pf_offset_d    = pf_offset_q;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    pmem_addr_sel  = 2'd0;
    lookup_sel     = 1'b0;
    data_in_sel    = 1'b0;
    data_we        = '0;
    ld_tag         = '0;
    ld_valid       = '0;
    ld_dirty       = '0;
    valid_in       = 1'b0;
    dirty_in       = 1'b0;
    ld_lru         = 1'b0;
    if (rst_n) begin
      case (state_q)
        CHECK: begin
          if (demand && hit) begin
            mem_resp = 1'b1;
            ld_lru   = 1'b1;
            if (mem_write) begin
              data_in_sel = 1'b1;
              data_we     = hit_oh;
              dirty_in    = 1'b1;
              ld_dirty    = hit_oh;
            end
          end else if (demand) begin
            state_d = victim_dirty ? WB : FILL;
          end else if (pf_remaining_q != '0) begin
            state_d = PF_PROBE;
          end
        end
        WB: begin
          pmem_addr_sel = 2'd0;
          pmem_write    = 1'b1;
          if (pmem_resp) begin
            ld_dirty = victim_oh;
            state_d  = FILL;
          end
        end
        FILL: begin
          pmem_addr_sel = 2'd1;
          pmem_read     = 1'b1;
          if (pmem_resp) begin
            data_we        = victim_oh;
            ld_tag         = victim_oh;
            ld_valid       = victim_oh;
            ld_dirty       = victim_oh;
            valid_in       = 1'b1;
            ld_lru         = 1'b1;
            pf_remaining_d = CNT_W'(PF_DEPTH);
            pf_offset_d    = CNT_W'(1);
            state_d        = CHECK;
          end
        end
        PF_PROBE: begin
          lookup_sel = 1'b1;
          state_d    = CHECK;
          if (pf_cross_page) begin
            pf_remaining_d = '0;
          end else if (hit) begin
            pf_remaining_d = rem_dec;
            pf_offset_d    = pf_offset_q + CNT_W'(1);
          end else if (victim_dirty) begin
            pf_remaining_d = '0;
          end else begin
            state_d = PF_FILL;
          end
        end
        PF_FILL: begin
          lookup_sel    = 1'b1;
          pmem_addr_sel = 2'd2;
          pmem_read     = 1'b1;
          if (pmem_resp) begin
            data_we        = victim_oh;
            ld_tag         = victim_oh;
            ld_valid       = victim_oh;
            ld_dirty       = victim_oh;
            valid_in       = 1'b1;
            pf_remaining_d = rem_dec;
            pf_offset_d    = pf_offset_q + CNT_W'(1);
            state_d        = CHECK;
          end
        end
        default: state_d = CHECK;
      endcase
    end
  end

  // State and prefetch bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= CHECK;
      pf_remaining_q <= '0;
      pf_offset_q    <= '0;
    end else begin
      state_q        <= state_d;
      pf_remaining_q <= pf_remaining_d;
      pf_offset_q    <= pf_offset_d;
    end
  end

`ifdef PF_STATS_EN
  logic pf_issue_evt, pf_drop_evt;
  assign pf_issue_evt = (state_q == PF_FILL) && pmem_resp;
  assign pf_drop_evt  = (state_q == PF_PROBE) && (pf_cross_page || (!hit && victim_dirty));

  // Saturating counters of issued prefetch fills and aborted prefetch sequences
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_issued_cnt  <= '0;
      pf_dropped_cnt <= '0;
    end else begin
      if (pf_issue_evt && pf_issued_cnt != 16'hFFFF) pf_issued_cnt <= pf_issued_cnt + 16'd1;
      if (pf_drop_evt && pf_dropped_cnt != 16'hFFFF) pf_dropped_cnt <= pf_dropped_cnt + 16'd1;
    end
  end
`endif

endmodule
